nonce_search_multi: RTL
=======================

# nonce_search_multi

Parametrised multi-lane successor to the single-lane micro-hash search system. It searches a bounded nonce range for a payload whose 24-bit micro-hash meets a byte-wise target. It instantiates LANES copies of the team's `micro_hash` core, issues LANES consecutive nonces per round, and reports the lowest passing nonce. It also reports an explicit not-found result when the range is exhausted, which the single-lane system cannot do.

## Interface
- LANES, 4, parallel hash cores per round; power of two, 1..8
- TGT_BYTES, 2, number of most-significant digest bytes compared against target; 1..3
- HASH_LAT, 66, cycles from core `start` to core `done`; identical for all lanes
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  request a search; sampled only in IDLE
- payload  in  96  message prefix; core message = {payload, nonce}
- target  in  8  per-byte threshold
- nonce_lo  in  32  first nonce, inclusive
- nonce_hi  in  32  last nonce, inclusive
- busy  out  1  high in ISSUE/WAIT/CHECK
- terminado  out  1  high while in DONE
- found  out  1  valid with terminado; 1 = passing nonce found
- nonceOut  out  32  passing nonce; last nonce tried when found=0
- hashOut  out  24  digest of nonceOut
- attempts  out  32  nonces hashed in this search

## Operation
- Inputs payload, target, nonce_lo and nonce_hi are latched on accepted start. Later changes are ignored until the next search.
- Pass rule: for each byte i in 0..TGT_BYTES-1 (counting from bit 23 down), digest byte i < target. Comparison is unsigned and strict, so target=0 never passes.
- cur is a 33-bit register loaded with nonce_lo. In a round, lane k hashes cur+k. A lane is masked when cur+k > nonce_hi.
- FSM:
  - IDLE: on start: if nonce_lo > nonce_hi → DONE with found=0 and attempts=0; else → ISSUE.
  - ISSUE: pulse `start` to all unmasked cores for one cycle; add the unmasked count to attempts → WAIT.
  - WAIT: hold until lane 0 `done` → CHECK.
  - CHECK: the lowest-index unmasked passing lane wins → DONE, found=1. If no lane passes and cur+LANES > nonce_hi → DONE, found=0, with nonceOut/hashOut taken from the highest unmasked lane. Otherwise cur += LANES → ISSUE.
  - DONE: hold all results. Leave for IDLE only when start=0. start held high keeps the block in DONE.
- Results (found, nonceOut, hashOut, attempts) persist through IDLE until the next accepted start, which clears found.
- nonce_hi=32'hFFFFFFFF must terminate. The 33-bit cur prevents wrap to 0.
- reset in any state: FSM → IDLE, cores reset, all outputs 0.

## Timing
- Reset values: busy=0, terminado=0, found=0, nonceOut=0, hashOut=0, attempts=0.
- start high in IDLE at edge n → busy=1 from n+1.
- One round takes HASH_LAT+3 cycles: ISSUE (1), WAIT (HASH_LAT+1), CHECK (1).
- A success in round r raises terminado at cycle n+1+r·(HASH_LAT+3). busy falls in the same cycle.
- Empty range: terminado=1 at n+1 with found=0.
- start and reset asserted together: reset wins.

## Configuration
- NONCE_SEARCH_ABORT_EN defined: adds input port `abort` (1 bit).
  - abort=1 in ISSUE/WAIT/CHECK → DONE next cycle with found=0, attempts frozen and cores reset.
  - abort is ignored in IDLE and DONE.
  - abort in the same cycle as a CHECK success: success wins.
- Not defined: no `abort` port; the search runs until success or exhaustion.

## Test plan
- Payload 96'h397d9f2f40ca9e6c6b1f3324, target 8'h0a, range 0..32'hFFFFFFFF, LANES=4 → found=1. nonceOut and hashOut equal the behavioural model's lowest passing nonce and its digest. attempts = 4·rounds.
- target 8'h00, range 0..15, LANES=4 → found=0 after 4 rounds, attempts=16, nonceOut=15, terminado at n+1+4·(HASH_LAT+3).
- Range 10..10 → a single round with 1 unmasked lane, attempts=1. A degenerate range nonce_lo=7, nonce_hi=6 → terminado at n+1, found=0, attempts=0.
- Range 32'hFFFFFFFE..32'hFFFFFFFF with target 8'h00 → found=0, attempts=2, and no wrap to nonce 0.
- Assert reset during WAIT of round 2 → all outputs 0 next cycle. A subsequent start re-runs the search and reproduces the first test's result.
- With NONCE_SEARCH_ABORT_EN, target 8'h00, range 0..1023: assert abort in round 3 WAIT → found=0, attempts=12. With start held high, terminado stays high; deassert start → IDLE.

Source files
------------

// File: rtl/nonce_search_multi.sv
// nonce_search_multi: bounded nonce search using LANES parallel micro_hash cores.
// Each round issues LANES consecutive nonces; the lowest passing nonce wins,
// and an exhausted range reports found=0 with the last nonce tried.
// Optional feature macro: NONCE_SEARCH_ABORT_EN adds the 'abort' input.

// micro_hash: iterative 24-bit digest of a 128-bit message.
// done pulses HASH_LAT cycles after start; digest is held until the next start.
module micro_hash #(
  parameter int HASH_LAT = 66
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [127:0] msg,
  output logic         done,
  output logic [23:0]  digest
);
  localparam int CW = $clog2(HASH_LAT);
  localparam logic [23:0] IV = 24'h6a09e6;

  logic [127:0]  msg_q;
  logic [23:0]   h_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  function automatic logic [23:0] mix(input logic [23:0] h, input logic [7:0] b);
    logic [23:0] t;
    t = (h ^ {16'h0000, b}) * 24'h000193;
    return {t[18:0], t[23:19]};
  endfunction

  function automatic logic [23:0] fin(input logic [23:0] h);
    logic [23:0] t;
    t = h ^ (h >> 11);
    t = t * 24'h2d6b35;
    return t ^ (t >> 13);
  endfunction

  // One message byte per cycle, then a finalisation step, then done.
  always_ff @(posedge clk) begin
    if (clr) begin
      run_q <= 1'b0;
      done  <= 1'b0;
      cnt_q <= '0;
      h_q   <= '0;
      msg_q <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run_q <= 1'b1;
        cnt_q <= CW'(HASH_LAT - 1);
        h_q   <= IV;
        msg_q <= msg;
      end else if (run_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q >= CW'(2)) begin
          h_q   <= mix(h_q, msg_q[127:120]);
          msg_q <= {msg_q[119:0], msg_q[127:120]};
        end else if (cnt_q == CW'(1)) begin
          h_q <= fin(h_q);
        end else begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign digest = h_q;
endmodule

// State table:
//   S_IDLE  | waiting for start; previous results still visible
//   S_ISSUE | start all unmasked cores, count their nonces
//   S_WAIT  | hashing in progress, wait for lane 0 done
//   S_CHECK | pick the lowest passing lane, or stop on exhaustion, or advance
//   S_DONE  | results held; leave once start is low
module nonce_search_multi #(
  parameter int LANES     = 4,
  parameter int TGT_BYTES = 2,
  parameter int HASH_LAT  = 66
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef NONCE_SEARCH_ABORT_EN
  input  logic        abort,
`endif
  input  logic [95:0] payload,
  input  logic [7:0]  target,
  input  logic [31:0] nonce_lo,
  input  logic [31:0] nonce_hi,
  output logic        busy,
  output logic        terminado,
  output logic        found,
  output logic [31:0] nonceOut,
  output logic [23:0] hashOut,
  output logic [31:0] attempts
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NW = $clog2(LANES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;
  state_t state;

  logic [95:0] payload_q;
  logic [7:0]  target_q;
  logic [31:0] hi_q;
  logic [32:0] cur_q;

  logic [32:0]      lane_n [LANES];
  logic [23:0]      dig [LANES];
  logic [LANES-1:0] mask, pass, core_start, core_done;
  logic [IW-1:0]    win_idx, last_idx;
  logic             win_any;
  logic [NW-1:0]    n_unmasked;
  logic             exhausted;
  logic             abort_kill;
  logic             core_clr;

  function automatic logic hash_ok(input logic [23:0] d, input logic [7:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < TGT_BYTES; i++)
      if (d[23-8*i -: 8] >= t) ok = 1'b0;
    return ok;
  endfunction

  // Per-lane nonce, range mask, pass flag, winner and highest live lane.
  always_comb begin
    win_any    = 1'b0;
    win_idx    = '0;
    last_idx   = '0;
    n_unmasked = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_n[k]     = cur_q + 33'(k);
      mask[k]       = lane_n[k] > {1'b0, hi_q};
      pass[k]       = !mask[k] && hash_ok(dig[k], target_q);
      core_start[k] = (state == S_ISSUE) && !mask[k] && !abort_kill;
      if (!mask[k]) begin
        last_idx   = IW'(k);
        n_unmasked = n_unmasked + NW'(1);
      end
    end
    for (int k = LANES - 1; k >= 0; k--) begin
      if (pass[k]) begin
        win_any = 1'b1;
        win_idx = IW'(k);
      end
    end
  end

  // The 33-bit compare lets a range ending at 32'hFFFFFFFF terminate.
  assign exhausted = (cur_q + 33'(LANES)) > {1'b0, hi_q};

`ifdef NONCE_SEARCH_ABORT_EN
  // A success found in CHECK takes priority over a same-cycle abort.
  assign abort_kill = abort && ((state == S_ISSUE) || (state == S_WAIT) ||
                                ((state == S_CHECK) && !win_any));
`else
  assign abort_kill = 1'b0;
`endif

  assign core_clr = reset || abort_kill;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    micro_hash #(.HASH_LAT(HASH_LAT)) u_core (
      .clk    (clk),
      .clr    (core_clr),
      .start  (core_start[k]),
      .msg    ({payload_q, lane_n[k][31:0]}),
      .done   (core_done[k]),
      .digest (dig[k])
    );
  end

  // Search sequencer with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      terminado <= 1'b0;
      found     <= 1'b0;
      nonceOut  <= '0;
      hashOut   <= '0;
      attempts  <= '0;
      payload_q <= '0;
      target_q  <= '0;
      hi_q      <= '0;
      cur_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            payload_q <= payload;
            target_q  <= target;
            hi_q      <= nonce_hi;
            cur_q     <= {1'b0, nonce_lo};
            found     <= 1'b0;
            attempts  <= '0;
            if (nonce_lo > nonce_hi) begin
              state     <= S_DONE;
              terminado <= 1'b1;
            end else begin
              state <= S_ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          attempts <= attempts + 32'(n_unmasked);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // All started lanes finish together; lane 0 is always started.
          if (|core_done) state <= S_CHECK;
        end
        S_CHECK: begin
          if (win_any) begin
            found     <= 1'b1;
            nonceOut  <= lane_n[win_idx][31:0];
            hashOut   <= dig[win_idx];
            busy      <= 1'b0;
            terminado <= 1'b1;
            state     <= S_DONE;
          end else if (exhausted) begin
            found     <= 1'b0;
            nonceOut  <= lane_n[last_idx][31:0];
            hashOut   <= dig[last_idx];
            busy      <= 1'b0;
            terminado <= 1'b1;
            state     <= S_DONE;
          end else begin
            cur_q <= cur_q + 33'(LANES);
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (!start) begin
            terminado <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (abort_kill) begin
        state     <= S_DONE;
        busy      <= 1'b0;
        terminado <= 1'b1;
        found     <= 1'b0;
        attempts  <= attempts;
      end
    end
  end
endmodule
